imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
- Controls the instruction memory in the fetch stage and decides who owns it: the program loader or the running core.
- During a load it holds the core frozen, writes a stream of instruction words into IMEM, then forces the PC to the boot address and releases fetch.
- While the core runs, the hazard unit's pc_write and IF_ID_write pass through unchanged.
- Sits between the hazard unit and the IF stage, and between the IF stage and the external loader interface.

Parameters:
- PC_WIDTH, 32, width of the PC and of IMEM byte addresses.
- INST_WIDTH, 32, instruction word width.
- MEM_DEPTH, 256, IMEM capacity in words; must be a power of 2 and at least 2.
- BOOT_ADDR, 0, byte address of the first loaded word and the PC value at release; must be 4-byte aligned.
- AUTO_LOAD, 1, selects the first state after reset: 1 = LOAD, 0 = IDLE.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse; requests a (re)load.
- ld_valid  in  1  loader word valid.
- ld_data  in  INST_WIDTH  loader instruction word.
- ld_last  in  1  marks the final word; qualified by ld_valid.
- ld_ready  out  1  controller accepts the word this cycle.
- imem_wr_en  out  1  IMEM write strobe.
- imem_wr_addr  out  PC_WIDTH  IMEM byte write address.
- imem_wr_data  out  INST_WIDTH  IMEM write data.
- hz_pc_write  in  1  pc_write from the hazard unit.
- hz_IF_ID_write  in  1  IF_ID_write from the hazard unit.
- pc_write  out  1  to the IF stage.
- IF_ID_write  out  1  to the IF stage.
- force_pc_sel  out  1  OR-ed into the IF stage pc_sel.
- force_pc  out  PC_WIDTH  muxed onto the IF stage pc_imm when force_pc_sel=1.
- word_count  out  $clog2(MEM_DEPTH)+1  words written in the current or last load.
- load_done  out  1  core is running a loaded image.
- load_error  out  1  sticky overflow flag.

Behaviour:

State machine: IDLE, LOAD, RELEASE, RUN, ERROR. All outputs are registered or decoded from state only; none is combinational from ld_valid, so there is no combinational valid-to-ready path.

Reset values (asynchronous, active-low):
- state = LOAD if AUTO_LOAD=1, else IDLE.
- word_count=0, load_done=0, load_error=0.
- imem_wr_en=0, imem_wr_addr=BOOT_ADDR, imem_wr_data=0.
- ld_ready = 1 if the reset state is LOAD, else 0.
- pc_write=0, IF_ID_write=0, force_pc_sel=0, force_pc=BOOT_ADDR.

IDLE:
- Core held: pc_write=0, IF_ID_write=0, ld_ready=0.
- load_start → LOAD.

LOAD:
- ld_ready=1 while word_count<MEM_DEPTH.
- Each handshake (ld_valid & ld_ready):
  - Next cycle: imem_wr_en=1, imem_wr_addr=BOOT_ADDR+4*word_count, imem_wr_data=ld_data (one-cycle write latency).
  - word_count increments by 1.
- ld_last on a handshake → RELEASE.
- Accepting word number MEM_DEPTH without ld_last → RELEASE.
- Core held the whole time: pc_write=0, IF_ID_write=0.
- Entering LOAD clears word_count and load_done, and sets the write address to BOOT_ADDR.

Overflow:
- ld_valid=1 while word_count==MEM_DEPTH in LOAD is impossible by construction; the state has already left.
- ld_valid=1 in RELEASE (the cycle after the final word was accepted) → ERROR. The release still completes; ERROR's outputs take effect next cycle.

RELEASE (exactly 1 cycle):
- Registered outputs: force_pc_sel=1, force_pc=BOOT_ADDR, pc_write=1, IF_ID_write=0, ld_ready=0.
- The last IMEM write, from the previous cycle, commits before the PC update.
- → RUN, with load_done=1.

RUN:
- pc_write=hz_pc_write, IF_ID_write=hz_IF_ID_write, force_pc_sel=0, ld_ready=0, imem_wr_en=0.
- load_start → LOAD. Next cycle pc_write=0, IF_ID_write=0; in-flight pipeline instructions are not flushed by this block.

ERROR:
- load_error=1 (sticky), ld_ready=0, core held, load_done=0.
- load_start → LOAD; load_error clears on that transition.

Other rules:
- load_start in LOAD or RELEASE is ignored.
- Addresses are computed modulo 2^PC_WIDTH.
- word_count saturates at MEM_DEPTH.
- Reset asserted mid-load aborts immediately to the reset values; any partially written IMEM contents are not restored.

Test Plan:
1. Reset with AUTO_LOAD=1; stream 3 words 0x00500093, 0x00100113, 0x002081B3 (last on the 3rd) → writes at 0x0, 0x4, 0x8, one cycle after each handshake; word_count=3; one RELEASE cycle with force_pc_sel=1, force_pc=0, pc_write=1; then load_done=1.
2. In RUN, toggle hz_pc_write / hz_IF_ID_write through 1/1, 0/0, 1/0 → pc_write and IF_ID_write follow the same cycle; imem_wr_en stays 0.
3. MEM_DEPTH=4; 4 words without ld_last → RELEASE after the 4th handshake; 5th word held valid → ld_ready=0, then ERROR with load_error=1; load_start → LOAD, load_error=0, word_count=0.
4. ld_valid gapped (1,0,0,1,1 with last) → exactly 3 writes at addresses 0x0, 0x4, 0x8; no write strobes in the gap cycles.
5. RUN, pulse load_start → pc_write=0 on the next cycle; reload 2 words at BOOT_ADDR=0x100 → writes at 0x100 and 0x104; force_pc=0x100.
6. reset_n low after the 2nd of 5 words → all outputs return to reset values asynchronously; after reset, a fresh load starts again at BOOT_ADDR.

Source files
------------

// File: rtl/imem_boot_ctrl_if.sv
// Bundle between the boot controller, the external program loader,
// the hazard unit and the IF stage. The slave view belongs to the
// controller; the master view belongs to whatever drives loader and
// hazard inputs and consumes the IMEM write port and fetch controls.
interface imem_boot_ctrl_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
);
  localparam int CW = $clog2(MEM_DEPTH) + 1;

  // Loader side
  logic                  load_start;
  logic                  ld_valid;
  logic [INST_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_ready;

  // IMEM write port
  logic                  imem_wr_en;
  logic [PC_WIDTH-1:0]   imem_wr_addr;
  logic [INST_WIDTH-1:0] imem_wr_data;

  // Hazard unit in, IF stage out
  logic                  hz_pc_write;
  logic                  hz_IF_ID_write;
  logic                  pc_write;
  logic                  IF_ID_write;
  logic                  force_pc_sel;
  logic [PC_WIDTH-1:0]   force_pc;

  // Status
  logic [CW-1:0]         word_count;
  logic                  load_done;
  logic                  load_error;

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last,
    input  hz_pc_write, hz_IF_ID_write,
    output ld_ready,
    output imem_wr_en, imem_wr_addr, imem_wr_data,
    output pc_write, IF_ID_write, force_pc_sel, force_pc,
    output word_count, load_done, load_error
  );

  modport master (
    output load_start, ld_valid, ld_data, ld_last,
    output hz_pc_write, hz_IF_ID_write,
    input  ld_ready,
    input  imem_wr_en, imem_wr_addr, imem_wr_data,
    input  pc_write, IF_ID_write, force_pc_sel, force_pc,
    input  word_count, load_done, load_error
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction memory boot controller.
// Arbitrates IMEM ownership between the program loader and the core:
// while loading, the core is frozen and incoming words are written to
// consecutive IMEM words starting at BOOT_ADDR; afterwards the PC is
// forced to BOOT_ADDR for one cycle and fetch is handed back to the
// hazard unit.
// MEM_DEPTH must be a power of two >= 2 and BOOT_ADDR 4-byte aligned.
module imem_boot_ctrl #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter int                  MEM_DEPTH  = 256,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter bit                  AUTO_LOAD  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  imem_boot_ctrl_if.slave  bus
);

  localparam int            CW        = $clog2(MEM_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(MEM_DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [CW-1:0]         r_word_count;
  logic                  r_wr_en;
  logic [PC_WIDTH-1:0]   r_wr_addr;
  logic [INST_WIDTH-1:0] r_wr_data;
  logic                  r_load_done;
  logic                  r_load_error;

  logic                  w_ld_ready;
  logic                  w_handshake;
  logic                  w_final_word;
  logic                  w_enter_load;
  logic [PC_WIDTH-1:0]   w_wr_offset;
  logic                  w_pc_write;
  logic                  w_IF_ID_write;
  logic                  w_force_pc_sel;

  // Ready depends only on state and the registered count, never on
  // ld_valid, so the loader sees no combinational valid-to-ready path.
  assign w_ld_ready   = (r_state == S_LOAD) && (r_word_count < DEPTH_CNT);
  assign w_handshake  = bus.ld_valid && w_ld_ready;
  assign w_final_word = bus.ld_last || (r_word_count == LAST_SLOT);
  assign w_enter_load = (w_next_state == S_LOAD) && (r_state != S_LOAD);

  // Byte offset of the word being accepted; wraps modulo 2^PC_WIDTH.
  assign w_wr_offset  = PC_WIDTH'({r_word_count, 2'b00});

  // State register; the power-on state depends on AUTO_LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (AUTO_LOAD) r_state <= S_LOAD;
      else           r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the fetch controls decoded from state alone.
  always_comb begin
    w_next_state   = r_state;
    w_pc_write     = 1'b0;
    w_IF_ID_write  = 1'b0;
    w_force_pc_sel = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_handshake && w_final_word) w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        w_pc_write     = 1'b1;
        w_force_pc_sel = 1'b1;
        if (bus.ld_valid) w_next_state = S_ERROR;
        else              w_next_state = S_RUN;
      end
      S_RUN: begin
        w_pc_write    = bus.hz_pc_write;
        w_IF_ID_write = bus.hz_IF_ID_write;
        if (bus.load_start) w_next_state = S_LOAD;
      end
      S_ERROR: begin
        if (bus.load_start) w_next_state = S_LOAD;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // IMEM write port: one cycle behind the handshake, address rewound
  // to BOOT_ADDR whenever a new load begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= BOOT_ADDR;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_handshake;
      if (w_enter_load) begin
        r_wr_addr <= BOOT_ADDR;
      end else if (w_handshake) begin
        r_wr_addr <= BOOT_ADDR + w_wr_offset;
        r_wr_data <= bus.ld_data;
      end
    end
  end

  // Word counter: cleared on entry to LOAD, saturating at MEM_DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_count <= '0;
    end else if (w_enter_load) begin
      r_word_count <= '0;
    end else if (w_handshake && (r_word_count < DEPTH_CNT)) begin
      r_word_count <= r_word_count + CW'(1);
    end
  end

  // Status flags: done is set when the release hands over to RUN, error
  // is sticky until the next load request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      if (w_enter_load || (w_next_state == S_ERROR)) begin
        r_load_done <= 1'b0;
      end else if ((r_state == S_RELEASE) && (w_next_state == S_RUN)) begin
        r_load_done <= 1'b1;
      end

      if (w_next_state == S_ERROR) begin
        r_load_error <= 1'b1;
      end else if ((r_state == S_ERROR) && (w_next_state == S_LOAD)) begin
        r_load_error <= 1'b0;
      end
    end
  end

  assign bus.ld_ready     = w_ld_ready;
  assign bus.imem_wr_en   = r_wr_en;
  assign bus.imem_wr_addr = r_wr_addr;
  assign bus.imem_wr_data = r_wr_data;
  assign bus.pc_write     = w_pc_write;
  assign bus.IF_ID_write  = w_IF_ID_write;
  assign bus.force_pc_sel = w_force_pc_sel;
  assign bus.force_pc     = BOOT_ADDR;
  assign bus.word_count   = r_word_count;
  assign bus.load_done    = r_load_done;
  assign bus.load_error   = r_load_error;

endmodule
